knn_sample_streamer: RTL and testbench

- Front-end that drives the training and test stream into the knn classifier pipeline and collects its vote.
- Holds a training set (32-bit sample, 2-bit label) in an internal synchronous RAM, loaded over a simple write port.
- On start: resets the classifier, streams every sample with its index, then drives label-0 bubbles to drain the pipeline.
- Captures res on res_vld and reports result/done/error to the controller.

---
 rtl/knn_stream_pkg.sv | 32 +++
 rtl/knn_sample_streamer_if.sv | 31 +++
 rtl/knn_sample_ram.sv | 45 ++++
 rtl/knn_sample_streamer.sv | 164 ++++++++++++++++
 tb/tb_knn_sample_streamer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/knn_stream_pkg.sv
// ============================================================================
// Module      : knn_stream_pkg
// Description : Shared types and constants for the knn sample streamer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package knn_stream_pkg;

  localparam int DATA_W  = 32;
  localparam int LABEL_W = 2;
  localparam int IDX_W   = 8;

  localparam logic [LABEL_W-1:0] LABEL_BUBBLE = 2'd0;
  localparam int                 MIN_SAMPLES  = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [LABEL_W-1:0] label;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/knn_sample_streamer_if.sv
// ============================================================================
// Module      : knn_sample_streamer_if
// Description : Streamer-to-classifier bus: sample stream out, vote back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface knn_sample_streamer_if;
  import knn_stream_pkg::*;

  logic               knn_rst;
  logic [DATA_W-1:0]  train_data;
  logic [DATA_W-1:0]  test_data;
  logic [LABEL_W-1:0] label;
  logic [IDX_W-1:0]   index;
  logic [LABEL_W-1:0] res;
  logic               res_vld;

  modport master (
    output knn_rst, train_data, test_data, label, index,
    input  res, res_vld
  );

  modport slave (
    input  knn_rst, train_data, test_data, label, index,
    output res, res_vld
  );

endinterface

`default_nettype wire

// File: rtl/knn_sample_ram.sv
// ============================================================================
// Module      : knn_sample_ram
// Description : Single-port training-set RAM with 1-cycle registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module knn_sample_ram
  import knn_stream_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_we,
  input  wire logic             i_re,
  input  wire logic [IDX_W-1:0] i_addr,
  input  wire entry_t           i_wdata,
  output entry_t                o_rdata
);

  entry_t r_mem [DEPTH];
  entry_t r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Output register reads as a bubble whenever no read was issued, so it can
  // drive the classifier stream directly.
  always_ff @(posedge clk) begin
    if (rst || !i_re) begin
      r_q <= '{data: '0, label: LABEL_BUBBLE};
    end else begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

`default_nettype wire

// File: rtl/knn_sample_streamer.sv
// ============================================================================
// Module      : knn_sample_streamer
// Description : Streams the stored training set into the knn pipeline and
//               collects its vote.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module knn_sample_streamer
  import knn_stream_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               wr_en,
  input  wire logic [IDX_W-1:0]   wr_addr,
  input  wire logic [DATA_W-1:0]  wr_data,
  input  wire logic [LABEL_W-1:0] wr_label,
  input  wire logic [8:0]         num_samples,
  input  wire logic [DATA_W-1:0]  test_in,
  input  wire logic               start,
  output logic                    busy,
  output logic                    done,
  output logic [LABEL_W-1:0]      result,
  output logic                    error,
  knn_sample_streamer_if.master   knn
);

  localparam int CNT_W = $clog2((TIMEOUT > CLR_CYCLES ? TIMEOUT : CLR_CYCLES) + 1);
  localparam logic [CNT_W-1:0] c_clr_last = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_to_last  = CNT_W'(TIMEOUT - 1);
  localparam logic [8:0]       c_min      = 9'(MIN_SAMPLES);
  localparam logic [8:0]       c_max      = 9'(DEPTH);

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [LABEL_W-1:0] r_result;
  logic               r_knn_rst;
  logic [DATA_W-1:0]  r_test_data;
  logic [IDX_W-1:0]   r_index;

  logic               w_rd_en;
  logic               w_wr_en;
  logic [IDX_W-1:0]   w_addr;
  entry_t             w_wdata;
  entry_t             w_rdata;

  assign w_rd_en = (r_state == ST_STREAM);
  assign w_wr_en = wr_en && (r_state == ST_IDLE);
  assign w_addr  = w_rd_en ? r_ptr : wr_addr;
  assign w_wdata = '{data: wr_data, label: wr_label};

  knn_sample_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_en),
    .i_re    (w_rd_en),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_last      <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_result    <= '0;
      r_knn_rst   <= 1'b1;
      r_test_data <= '0;
      r_index     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_knn_rst <= 1'b0;
      // Index travels alongside the RAM read so it lines up with its sample.
      r_index   <= w_rd_en ? r_ptr : '0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (num_samples >= c_min && num_samples <= c_max) begin
              r_state     <= ST_CLEAR;
              r_busy      <= 1'b1;
              r_error     <= 1'b0;
              r_knn_rst   <= 1'b1;
              r_test_data <= test_in;
              r_last      <= IDX_W'(num_samples - 9'd1);
              r_cnt       <= '0;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          if (r_cnt == c_clr_last) begin
            r_state <= ST_STREAM;
            r_ptr   <= '0;
          end else begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_knn_rst <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (r_ptr == r_last) begin
            r_state <= ST_DRAIN;
            r_cnt   <= '0;
          end else begin
            r_ptr <= r_ptr + IDX_W'(1);
          end
        end
        ST_DRAIN: begin
          if (knn.res_vld) begin
            r_result <= knn.res;
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_error  <= 1'b0;
          end else if (r_cnt == c_to_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign result         = r_result;
  assign error          = r_error;
  assign knn.knn_rst    = r_knn_rst;
  assign knn.train_data = w_rdata.data;
  assign knn.label      = w_rdata.label;
  assign knn.index      = r_index;
  assign knn.test_data  = r_test_data;

endmodule

`default_nettype wire

// File: tb/tb_knn_sample_streamer.sv
// ============================================================================
// Module      : tb_knn_sample_streamer
// Description : Directed self-checking bench for the knn sample streamer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_knn_sample_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_label;
  logic [8:0]  num_samples;
  logic [31:0] test_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  result;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] data_tbl  [8];
  logic [1:0]  label_tbl [8];

  knn_sample_streamer_if bus ();

  knn_sample_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_label    (wr_label),
    .num_samples (num_samples),
    .test_in     (test_in),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .error       (error),
    .knn         (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   64'(busy), 64'd0);
    check({tag, "_done"},   64'(done), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_error"},  64'(error), 64'd0);
    check({tag, "_krst"},   64'(bus.knn_rst), 64'd1);
    check({tag, "_train"},  64'(bus.train_data), 64'd0);
    check({tag, "_test"},   64'(bus.test_data), 64'd0);
    check({tag, "_label"},  64'(bus.label), 64'd0);
    check({tag, "_index"},  64'(bus.index), 64'd0);
  endtask

  task automatic pulse_start(input logic [8:0] n, input logic [31:0] tin);
    num_samples = n;
    test_in     = tin;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic finish_with_vote(input logic [1:0] vote, input string tag);
    bus.res     = vote;
    bus.res_vld = 1'b1;
    tick();
    bus.res_vld = 1'b0;
    check({tag, "_done"},   64'(done), 64'd1);
    check({tag, "_busy"},   64'(busy), 64'd0);
    check({tag, "_result"}, 64'(result), 64'(vote));
    check({tag, "_error"},  64'(error), 64'd0);
    tick();
    check({tag, "_done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      data_tbl[i] = 32'h0102_0304 + 32'(i) * 32'h1111_1111;
    end
    label_tbl = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd3, 2'd1, 2'd2, 2'd1};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_label = '0;
    num_samples = '0; test_in = '0; start = 1'b0;
    bus.res = '0; bus.res_vld = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = data_tbl[i]; wr_label = label_tbl[i];
      tick();
    end
    wr_en = 1'b0;

    // Run 1: full stream of 8 samples, vote returned in drain
    pulse_start(9'd8, data_tbl[0]);
    check("r1_busy_t1", 64'(busy), 64'd1);
    check("r1_krst_t1", 64'(bus.knn_rst), 64'd1);
    check("r1_test_t1", 64'(bus.test_data), 64'(data_tbl[0]));
    tick();
    check("r1_krst_t2", 64'(bus.knn_rst), 64'd1);
    tick();
    check("r1_krst_t3", 64'(bus.knn_rst), 64'd0);
    check("r1_label_t3", 64'(bus.label), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("r1_index", 64'(bus.index), 64'(i));
      check("r1_label", 64'(bus.label), 64'(label_tbl[i]));
      check("r1_train", 64'(bus.train_data), 64'(data_tbl[i]));
    end
    tick();
    check("r1_bub_label", 64'(bus.label), 64'd0);
    check("r1_bub_train", 64'(bus.train_data), 64'd0);
    check("r1_bub_index", 64'(bus.index), 64'd0);
    check("r1_bub_busy", 64'(busy), 64'd1);
    check("r1_bub_test", 64'(bus.test_data), 64'(data_tbl[0]));
    finish_with_vote(2'd1, "r1");

    // Too few samples
    pulse_start(9'd4, 32'h0);
    check("small_done", 64'(done), 64'd1);
    check("small_error", 64'(error), 64'd1);
    check("small_busy", 64'(busy), 64'd0);
    check("small_result", 64'(result), 64'd1);
    check("small_krst", 64'(bus.knn_rst), 64'd0);
    check("small_label", 64'(bus.label), 64'd0);
    check("small_index", 64'(bus.index), 64'd0);
    tick();
    check("small_done_low", 64'(done), 64'd0);
    check("small_error_hold", 64'(error), 64'd1);
    check("small_krst2", 64'(bus.knn_rst), 64'd0);

    // Too many samples
    pulse_start(9'd300, 32'h0);
    check("big_done", 64'(done), 64'd1);
    check("big_error", 64'(error), 64'd1);
    check("big_krst", 64'(bus.knn_rst), 64'd0);
    tick();
    check("big_done_low", 64'(done), 64'd0);

    // Timeout: no vote in drain, stray res_vld during STREAM ignored
    pulse_start(9'd5, 32'hCAFE_0001);
    check("to_error_clr", 64'(error), 64'd0);
    check("to_busy", 64'(busy), 64'd1);
    repeat (3) tick();
    bus.res = 2'd3; bus.res_vld = 1'b1;
    tick();
    bus.res_vld = 1'b0;
    check("to_ignore_done", 64'(done), 64'd0);
    repeat (66) tick();
    check("to_pre_done", 64'(done), 64'd0);
    check("to_pre_busy", 64'(busy), 64'd1);
    check("to_test_hold", 64'(bus.test_data), 64'hCAFE_0001);
    tick();
    check("to_done", 64'(done), 64'd1);
    check("to_error", 64'(error), 64'd1);
    check("to_result_kept", 64'(result), 64'd1);
    check("to_busy_low", 64'(busy), 64'd0);
    tick();

    // start and wr_en during STREAM are ignored
    pulse_start(9'd8, data_tbl[1]);
    repeat (3) tick();
    start = 1'b1; wr_en = 1'b1; wr_addr = 8'd2; wr_data = 32'hDEAD_BEEF; wr_label = 2'd3;
    tick();
    start = 1'b0; wr_en = 1'b0;
    check("ign_busy", 64'(busy), 64'd1);
    check("ign_krst", 64'(bus.knn_rst), 64'd0);
    check("ign_index", 64'(bus.index), 64'd1);
    repeat (7) tick();
    check("ign_bubble", 64'(bus.label), 64'd0);
    finish_with_vote(2'd2, "ign");

    pulse_start(9'd8, data_tbl[2]);
    repeat (5) tick();
    check("rb_index", 64'(bus.index), 64'd2);
    check("rb_train", 64'(bus.train_data), 64'(data_tbl[2]));
    check("rb_label", 64'(bus.label), 64'(label_tbl[2]));
    repeat (6) tick();
    finish_with_vote(2'd3, "rb");

    // Reset on the third STREAM cycle
    pulse_start(9'd8, data_tbl[3]);
    repeat (4) tick();
    check("ab_streaming", 64'(bus.index), 64'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("ab");
    rst = 1'b0;
    tick();
    check("ab_no_done", 64'(done), 64'd0);
    check("ab_idle_busy", 64'(busy), 64'd0);
    check("ab_krst_low", 64'(bus.knn_rst), 64'd0);
    tick();
    check("ab_no_done2", 64'(done), 64'd0);

    pulse_start(9'd8, data_tbl[0]);
    check("post_busy", 64'(busy), 64'd1);
    repeat (3) tick();
    check("post_index0", 64'(bus.index), 64'd0);
    check("post_label0", 64'(bus.label), 64'(label_tbl[0]));
    repeat (8) tick();
    finish_with_vote(2'd1, "post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
